matrix_alu_2x2_seq: RTL and testbench

MATRIX_ALU_2X2_SEQ -- requirements
Module: matrix_alu_2x2_seq

---
 rtl/matrix_alu_pkg.sv | 26 ++
 rtl/matrix_alu_2x2_seq_mac2.sv | 26 ++
 rtl/matrix_alu_2x2_seq.sv | 169 ++++++++++++++++
 tb/tb_matrix_alu_2x2_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_alu_pkg.sv
// Shared types for the 2x2 matrix ALU: opcode and FSM state encodings,
// plus the result-width helper.
package matrix_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_SCL = 3'd3,
      OP_TRN = 3'd4,
      OP_DET = 3'd5,
      OP_ADJ = 3'd6,
      OP_RSV = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int rw(input int w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/matrix_alu_2x2_seq_mac2.sv
// mac2: combinational two-term multiply-accumulate, p = x0*y0 +/- x1*y1,
// exact in 2*W+1 bits.
module mac2
   import matrix_alu_pkg::*;
#(
   parameter int W = 4,
   localparam int RW = rw(W)
) (
   input  logic signed [W-1:0]  i_x0,
   input  logic signed [W-1:0]  i_y0,
   input  logic signed [W-1:0]  i_x1,
   input  logic signed [W-1:0]  i_y1,
   input  logic                 i_sub,
   output logic signed [RW-1:0] o_p
);

   logic signed [RW-1:0] w_p0;
   logic signed [RW-1:0] w_p1;

   always_comb begin
      w_p0 = RW'(i_x0) * RW'(i_y0);
      w_p1 = RW'(i_x1) * RW'(i_y1);
      o_p  = i_sub ? (w_p0 - w_p1) : (w_p0 + w_p1);
   end

endmodule

// File: rtl/matrix_alu_2x2_seq.sv
// Sequential 2x2 signed matrix ALU with valid/ready handshakes.
// Define MATRIX_ALU_ADJ_EN to enable the adjugate op (op 6); otherwise op 6 is reserved.
module matrix_alu_2x2_seq
   import matrix_alu_pkg::*;
#(
   parameter int W = 4,
   localparam int RW = rw(W)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [4*W-1:0]  A,
   input  logic [4*W-1:0]  B,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*RW-1:0] C,
   output logic            err
);

   state_e               r_state;
   state_e               w_state_nxt;
   op_e                  r_op;
   logic [4*W-1:0]       r_a;
   logic [4*W-1:0]       r_b;
   logic [1:0]           r_cnt;
   logic                 r_rdy;
   logic [4*RW-1:0]      r_c;
   logic                 r_err;

   logic signed [W-1:0]  w_a [4];
   logic signed [W-1:0]  w_b [4];
   logic signed [W-1:0]  w_mx0, w_my0, w_mx1, w_my1;
   logic                 w_msub;
   logic signed [RW-1:0] w_mac;
   logic signed [RW-1:0] w_e [4];
   logic [4*RW-1:0]      w_c_mul;
   logic                 w_err_nxt;
   logic                 w_last;
   logic                 w_accept;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         w_a[i] = r_a[(3-i)*W +: W];
         w_b[i] = r_b[(3-i)*W +: W];
      end
   end

   // MAC defaults to the determinant; MUL steers row {cnt[1]} x column {cnt[0]}
   always_comb begin
      w_mx0  = w_a[0];
      w_my0  = w_a[3];
      w_mx1  = w_a[1];
      w_my1  = w_a[2];
      w_msub = 1'b1;
      if (r_op == OP_MUL) begin
         w_mx0  = w_a[{r_cnt[1], 1'b0}];
         w_my0  = w_b[{1'b0, r_cnt[0]}];
         w_mx1  = w_a[{r_cnt[1], 1'b1}];
         w_my1  = w_b[{1'b1, r_cnt[0]}];
         w_msub = 1'b0;
      end
   end

   mac2 #(.W(W)) u_mac2 (
      .i_x0  (w_mx0),
      .i_y0  (w_my0),
      .i_x1  (w_mx1),
      .i_y1  (w_my1),
      .i_sub (w_msub),
      .o_p   (w_mac)
   );

   always_comb begin
      w_err_nxt = 1'b0;
      for (int unsigned i = 0; i < 4; i++) w_e[i] = '0;
      case (r_op)
         OP_ADD: for (int unsigned i = 0; i < 4; i++) w_e[i] = RW'(w_a[i]) + RW'(w_b[i]);
         OP_SUB: for (int unsigned i = 0; i < 4; i++) w_e[i] = RW'(w_a[i]) - RW'(w_b[i]);
         OP_SCL: for (int unsigned i = 0; i < 4; i++) w_e[i] = RW'(w_b[3]) * RW'(w_a[i]);
         OP_TRN: begin
            w_e[0] = RW'(w_a[0]);
            w_e[1] = RW'(w_a[2]);
            w_e[2] = RW'(w_a[1]);
            w_e[3] = RW'(w_a[3]);
         end
         OP_DET: w_e[0] = w_mac;
         OP_MUL: w_err_nxt = 1'b0;
`ifdef MATRIX_ALU_ADJ_EN
         OP_ADJ: begin
            w_e[0]    = RW'(w_a[3]);
            w_e[1]    = -RW'(w_a[1]);
            w_e[2]    = -RW'(w_a[2]);
            w_e[3]    = RW'(w_a[0]);
            w_err_nxt = (w_mac == '0);
         end
`endif
         default: w_err_nxt = 1'b1;
      endcase

      w_c_mul = r_c;
      case (r_cnt)
         2'd0:    w_c_mul[4*RW-1:3*RW] = w_mac;
         2'd1:    w_c_mul[3*RW-1:2*RW] = w_mac;
         2'd2:    w_c_mul[2*RW-1:RW]   = w_mac;
         default: w_c_mul[RW-1:0]      = w_mac;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_last      = (r_op == OP_MUL) ? (r_cnt == 2'd3) :
                    (r_op == OP_DET) ? (r_cnt == 2'd1) : 1'b1;
      case (r_state)
         ST_IDLE: begin
            in_ready = r_rdy;
            if (in_valid && r_rdy) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // r_rdy keeps in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy <= 1'b0;
         r_op  <= OP_ADD;
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_c   <= '0;
         r_err <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (w_accept) begin
            r_op  <= op_e'(op);
            r_a   <= A;
            r_b   <= B;
            r_cnt <= '0;
         end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_op == OP_MUL) r_c <= w_c_mul;
            else if (w_last)    r_c <= {w_e[0], w_e[1], w_e[2], w_e[3]};
            if (w_last) r_err <= w_err_nxt;
         end
      end
   end

   assign C   = r_c;
   assign err = r_err;

endmodule

// File: tb/tb_matrix_alu_2x2_seq.sv
// Randomized self-checking bench for matrix_alu_2x2_seq against an integer matrix model.
module tb_matrix_alu_2x2_seq;

   localparam int W  = 4;
   localparam int RW = 2 * W + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2:0]      op = '0;
   logic [4*W-1:0]  A = '0;
   logic [4*W-1:0]  B = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [4*RW-1:0] C;
   logic            err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   matrix_alu_2x2_seq #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (C),
      .err       (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int el(input logic [4*W-1:0] v, input int idx);
      logic signed [W-1:0] e;
      e = v[(3-idx)*W +: W];
      return int'(e);
   endfunction

   function automatic logic [4*W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
      int e[4];
      logic [4*W-1:0] v;
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) v[(3-i)*W +: W] = e[i][W-1:0];
      return v;
   endfunction

   // Matrix-level reference: 2x2 integer arithmetic, then pack into RW-bit fields
   task automatic model(input int o, input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                        output logic [4*RW-1:0] c, output logic e, output int lat);
      int m[4];
      int ae[4];
      int be[4];
      int det;
      for (int i = 0; i < 4; i++) begin
         ae[i] = el(a, i);
         be[i] = el(b, i);
         m[i]  = 0;
      end
      det = ae[0] * ae[3] - ae[1] * ae[2];
      e   = 1'b0;
      lat = 1;
      case (o)
         0: for (int i = 0; i < 4; i++) m[i] = ae[i] + be[i];
         1: for (int i = 0; i < 4; i++) m[i] = ae[i] - be[i];
         2: begin
            lat = 4;
            for (int r = 0; r < 2; r++)
               for (int k = 0; k < 2; k++)
                  m[2*r+k] = ae[2*r] * be[k] + ae[2*r+1] * be[2+k];
         end
         3: for (int i = 0; i < 4; i++) m[i] = be[3] * ae[i];
         4: m = '{ae[0], ae[2], ae[1], ae[3]};
         5: begin
            lat  = 2;
            m[0] = det;
         end
`ifdef MATRIX_ALU_ADJ_EN
         6: begin
            m = '{ae[3], -ae[1], -ae[2], ae[0]};
            e = (det == 0);
         end
`endif
         default: e = 1'b1;
      endcase
      for (int i = 0; i < 4; i++) c[(3-i)*RW +: RW] = m[i][RW-1:0];
   endtask

   // Entered and left at posedge+1 with the DUT idle and ready
   task automatic run_op(input int o, input logic [4*W-1:0] a, input logic [4*W-1:0] b, input int hold);
      logic [4*RW-1:0] ec;
      logic ee;
      int elat;
      int cyc;
      bit rdy_bad;
      bit hold_bad;
      model(o, a, b, ec, ee, elat);
      check("ready_idle", in_ready, 1);
      op = o[2:0];
      A = a;
      B = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = $urandom_range(0, 1);
      op = 3'($urandom);
      A = 16'($urandom);
      B = 16'($urandom);
      cyc = 0;
      rdy_bad = 1'b0;
      while (!out_valid && cyc < 12) begin
         if (in_ready) rdy_bad = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("latency", cyc, elat);
      check("ready_low_busy", rdy_bad, 0);
      check("C", C, ec);
      check("err", err, ee);
      hold_bad = 1'b0;
      repeat (hold) begin
         @(posedge clk);
         #1;
         if (C !== ec || err !== ee || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
      end
      check("backpressure_hold", hold_bad, 0);
      out_ready = 1'b1;
      in_valid = 1'b1;
      check("ready_at_handshake", in_ready, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("valid_after_hs", out_valid, 0);
      check("ready_after_hs", in_ready, 1);
   endtask

   initial begin
      bit seen;
      #1 rst_n = 1'b0;
      #2;
      check("rst_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_C", C, 0);
      check("rst_err", err, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready_held", in_ready, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_release", in_ready, 1);

      run_op(0, pk(7, -8, 3, 0), pk(7, -8, -1, 5), 0);
      run_op(2, pk(1, 2, 3, 4), pk(5, 6, 7, -8), 0);
      run_op(5, pk(-8, -8, -8, 7), pk(0, 0, 0, 0), 0);
      run_op(3, pk(-8, 1, 0, 7), pk(0, 0, 0, -8), 0);
      run_op(6, pk(2, 4, 1, 2), pk(0, 0, 0, 0), 0);
      run_op(6, pk(3, 1, 1, 1), pk(0, 0, 0, 0), 0);
      run_op(7, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0);
      run_op(4, pk(1, -2, 3, -4), pk(0, 0, 0, 0), 0);
      run_op(1, pk(-8, 7, -8, 7), pk(7, -8, 7, -8), 0);
      run_op(0, pk(3, 3, 3, 3), pk(2, 2, 2, 2), 5);

      // reset pulsed in the second BUSY cycle of a MUL
      op = 3'd2;
      A = pk(1, 2, 3, 4);
      B = pk(5, 6, 7, -8);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midmul_rst_valid", out_valid, 0);
      check("midmul_rst_C", C, 0);
      check("midmul_rst_ready", in_ready, 0);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      check("midmul_no_result", seen, 0);
      check("midmul_C_zero", C, 0);
      check("midmul_ready", in_ready, 1);

      for (int n = 0; n < 200; n++)
         run_op(int'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
